// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller (master) and the datapath/memory side (slave).
interface multicycle_ctrl_if #(
  parameter int unsigned ALUFCT_W = 3
);
  logic [6:0]          Opcode;
  logic [2:0]          Funct3;
  logic                Funct7b5;
  logic                ImemReady;
  logic                DmemReady;

  logic                PCwrite;
  logic                PCwriteCond;
  logic                AluSrcA;
  logic [1:0]          AluSrcB;
  logic [ALUFCT_W-1:0] ALUFct;
  logic                AluAlt;
  logic                ImemRead;
  logic                LoadIr;
  logic                LoadAB;
  logic                DmemRead;
  logic                DmemWrite;
  logic                RegWrite;
  logic                MemToReg;
  logic                Fault;
  logic [3:0]          State;

  modport master (
    input  Opcode, Funct3, Funct7b5, ImemReady, DmemReady,
    output PCwrite, PCwriteCond, AluSrcA, AluSrcB, ALUFct, AluAlt, ImemRead, LoadIr,
           LoadAB, DmemRead, DmemWrite, RegWrite, MemToReg, Fault, State
  );

  modport slave (
    output Opcode, Funct3, Funct7b5, ImemReady, DmemReady,
    input  PCwrite, PCwriteCond, AluSrcA, AluSrcB, ALUFct, AluAlt, ImemRead, LoadIr,
           LoadAB, DmemRead, DmemWrite, RegWrite, MemToReg, Fault, State
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I-subset control FSM: fetch/decode/execute/memory/write-back sequencing
// with valid/ready memory handshakes and a wait watchdog that drops into a sticky FAULT.
module multicycle_ctrl #(
  parameter int unsigned ALUFCT_W    = 3,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter logic [1:0]  PC_STEP_SEL = 2'b01
) (
  input  logic              Clk,
  input  logic              Reset,
  multicycle_ctrl_if.master bus
);
  localparam logic [3:0] INIT   = 4'd0;
  localparam logic [3:0] FETCH  = 4'd1;
  localparam logic [3:0] UPDATE = 4'd2;
  localparam logic [3:0] DECODE = 4'd3;
  localparam logic [3:0] EXEC_R = 4'd4;
  localparam logic [3:0] EXEC_I = 4'd5;
  localparam logic [3:0] ADDR   = 4'd6;
  localparam logic [3:0] MEM_RD = 4'd7;
  localparam logic [3:0] MEM_WR = 4'd8;
  localparam logic [3:0] WB_ALU = 4'd9;
  localparam logic [3:0] WB_MEM = 4'd10;
  localparam logic [3:0] BRANCH = 4'd11;
  localparam logic [3:0] FAULT  = 4'd12;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BIMM = 2'b11;

  localparam logic [ALUFCT_W-1:0] FCT_ADD = ALUFCT_W'(3'b001);
  localparam logic [ALUFCT_W-1:0] FCT_SUB = ALUFCT_W'(3'b010);

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  logic [3:0]       state;
  logic [3:0]       state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             waiting;
  logic             timeout;

  assign waiting   = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
  assign timeout   = (MEM_TIMEOUT != 0) && (wait_cnt == CNT_W'(MEM_TIMEOUT));
  assign bus.State = state;

  // State register; the wait counter restarts on every state change and counts stalled cycles.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= INIT;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        wait_cnt <= '0;
      else if (waiting)
        wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Next state and Moore control decode.
  always_comb begin
    state_nxt       = state;
    bus.PCwrite     = 1'b0;
    bus.PCwriteCond = 1'b0;
    bus.AluSrcA     = 1'b0;
    bus.AluSrcB     = SRCB_REG;
    bus.ALUFct      = '0;
    bus.AluAlt      = 1'b0;
    bus.ImemRead    = 1'b0;
    bus.LoadIr      = 1'b0;
    bus.LoadAB      = 1'b0;
    bus.DmemRead    = 1'b0;
    bus.DmemWrite   = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.MemToReg    = 1'b0;
    bus.Fault       = 1'b0;

    case (state)
      INIT: state_nxt = FETCH;
      FETCH: begin
        bus.ImemRead = 1'b1;
        bus.AluSrcB  = PC_STEP_SEL;
        bus.ALUFct   = FCT_ADD;
        if (bus.ImemReady) state_nxt = UPDATE;
        else if (timeout)  state_nxt = FAULT;
      end
      UPDATE: begin
        bus.PCwrite = 1'b1;
        bus.LoadIr  = 1'b1;
        bus.AluSrcB = PC_STEP_SEL;
        bus.ALUFct  = FCT_ADD;
        state_nxt   = DECODE;
      end
      DECODE: begin
        // Speculatively form the branch target in ALUOut while the registers load.
        bus.LoadAB  = 1'b1;
        bus.AluSrcB = SRCB_BIMM;
        bus.ALUFct  = FCT_ADD;
        case (bus.Opcode)
          OP_R:              state_nxt = EXEC_R;
          OP_I:              state_nxt = EXEC_I;
          OP_LOAD, OP_STORE: state_nxt = ADDR;
          OP_BRANCH:         state_nxt = BRANCH;
          default:           state_nxt = FAULT;
        endcase
      end
      EXEC_R: begin
        bus.AluSrcA = 1'b1;
        bus.ALUFct  = ALUFCT_W'(bus.Funct3);
        bus.AluAlt  = bus.Funct7b5;
        state_nxt   = WB_ALU;
      end
      EXEC_I: begin
        // Only the shift-right immediate encodes SRA in IR[30]; elsewhere it is immediate data.
        bus.AluSrcA = 1'b1;
        bus.AluSrcB = SRCB_IMM;
        bus.ALUFct  = ALUFCT_W'(bus.Funct3);
        bus.AluAlt  = (bus.Funct3 == 3'b101) ? bus.Funct7b5 : 1'b0;
        state_nxt   = WB_ALU;
      end
      ADDR: begin
        bus.AluSrcA = 1'b1;
        bus.AluSrcB = SRCB_IMM;
        bus.ALUFct  = FCT_ADD;
        state_nxt   = (bus.Opcode == OP_LOAD) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        bus.DmemRead = 1'b1;
        if (bus.DmemReady) state_nxt = WB_MEM;
        else if (timeout)  state_nxt = FAULT;
      end
      MEM_WR: begin
        bus.DmemWrite = 1'b1;
        if (bus.DmemReady) state_nxt = FETCH;
        else if (timeout)  state_nxt = FAULT;
      end
      WB_ALU: begin
        bus.RegWrite = 1'b1;
        state_nxt    = FETCH;
      end
      WB_MEM: begin
        bus.RegWrite = 1'b1;
        bus.MemToReg = 1'b1;
        state_nxt    = FETCH;
      end
      BRANCH: begin
        bus.AluSrcA     = 1'b1;
        bus.ALUFct      = FCT_SUB;
        bus.PCwriteCond = 1'b1;
        state_nxt       = FETCH;
      end
      FAULT:   bus.Fault = 1'b1;
      default: state_nxt = FAULT;
    endcase
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instruction walks, memory stalls, watchdog and fault/reset cases.
module tb_multicycle_ctrl;
  localparam logic [3:0] S_INIT   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_UPDATE = 4'd2;
  localparam logic [3:0] S_DECODE = 4'd3;
  localparam logic [3:0] S_EXEC_R = 4'd4;
  localparam logic [3:0] S_EXEC_I = 4'd5;
  localparam logic [3:0] S_ADDR   = 4'd6;
  localparam logic [3:0] S_MEM_RD = 4'd7;
  localparam logic [3:0] S_MEM_WR = 4'd8;
  localparam logic [3:0] S_WB_ALU = 4'd9;
  localparam logic [3:0] S_WB_MEM = 4'd10;
  localparam logic [3:0] S_BRANCH = 4'd11;
  localparam logic [3:0] S_FAULT  = 4'd12;

  // Control word: {PCwrite,PCwriteCond,AluSrcA, AluSrcB, ALUFct, AluAlt,
  //                ImemRead,LoadIr,LoadAB,DmemRead,DmemWrite,RegWrite,MemToReg,Fault}
  localparam logic [16:0] CW_NONE    = '0;
  localparam logic [16:0] CW_FETCH   = {3'b000, 2'b01, 3'b001, 1'b0, 8'b1000_0000};
  localparam logic [16:0] CW_UPDATE  = {3'b100, 2'b01, 3'b001, 1'b0, 8'b0100_0000};
  localparam logic [16:0] CW_DECODE  = {3'b000, 2'b11, 3'b001, 1'b0, 8'b0010_0000};
  localparam logic [16:0] CW_EXR_ADD = {3'b001, 2'b00, 3'b000, 1'b0, 8'b0000_0000};
  localparam logic [16:0] CW_EXR_SRA = {3'b001, 2'b00, 3'b101, 1'b1, 8'b0000_0000};
  localparam logic [16:0] CW_EXI_SRA = {3'b001, 2'b10, 3'b101, 1'b1, 8'b0000_0000};
  localparam logic [16:0] CW_EXI_ADD = {3'b001, 2'b10, 3'b000, 1'b0, 8'b0000_0000};
  localparam logic [16:0] CW_ADDR    = {3'b001, 2'b10, 3'b001, 1'b0, 8'b0000_0000};
  localparam logic [16:0] CW_MEM_RD  = {3'b000, 2'b00, 3'b000, 1'b0, 8'b0001_0000};
  localparam logic [16:0] CW_MEM_WR  = {3'b000, 2'b00, 3'b000, 1'b0, 8'b0000_1000};
  localparam logic [16:0] CW_WB_ALU  = {3'b000, 2'b00, 3'b000, 1'b0, 8'b0000_0100};
  localparam logic [16:0] CW_WB_MEM  = {3'b000, 2'b00, 3'b000, 1'b0, 8'b0000_0110};
  localparam logic [16:0] CW_BRANCH  = {3'b011, 2'b00, 3'b010, 1'b0, 8'b0000_0000};
  localparam logic [16:0] CW_FAULT   = {3'b000, 2'b00, 3'b000, 1'b0, 8'b0000_0001};

  logic        Clk;
  logic        Reset;
  logic [16:0] obs_cw;
  int          checks;
  int          errors;

  multicycle_ctrl_if #(.ALUFCT_W(3)) bus ();

  multicycle_ctrl #(
    .ALUFCT_W   (3),
    .MEM_TIMEOUT(15),
    .PC_STEP_SEL(2'b01)
  ) u_dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  assign obs_cw = {bus.PCwrite, bus.PCwriteCond, bus.AluSrcA, bus.AluSrcB, bus.ALUFct, bus.AluAlt,
                   bus.ImemRead, bus.LoadIr, bus.LoadAB, bus.DmemRead, bus.DmemWrite,
                   bus.RegWrite, bus.MemToReg, bus.Fault};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_st(input string tag, input logic [3:0] st, input logic [16:0] cw);
    check_eq({tag, "/state"}, 32'(bus.State), 32'(st));
    check_eq({tag, "/ctrl"}, 32'(obs_cw), 32'(cw));
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7b5);
    bus.Opcode   = op;
    bus.Funct3   = f3;
    bus.Funct7b5 = f7b5;
  endtask

  // Hold reset across one clock edge and come back sampled in FETCH.
  task automatic do_reset(input string tag);
    Reset = 1'b1;
    #1;
    expect_st({tag, "/asserted"}, S_INIT, CW_NONE);
    tick();
    Reset = 1'b0;
    expect_st({tag, "/released"}, S_INIT, CW_NONE);
    tick();
    expect_st({tag, "/fetch"}, S_FETCH, CW_FETCH);
  endtask

  // Entered and left with FETCH sampled.
  task automatic run_alu(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic f7b5, input logic [3:0] ex_st, input logic [16:0] ex_cw);
    set_instr(op, f3, f7b5);
    bus.ImemReady = 1'b1;
    expect_st({tag, "/c1"}, S_FETCH, CW_FETCH);
    tick(); expect_st({tag, "/c2"}, S_UPDATE, CW_UPDATE);
    tick(); expect_st({tag, "/c3"}, S_DECODE, CW_DECODE);
    tick(); expect_st({tag, "/c4"}, ex_st, ex_cw);
    tick(); expect_st({tag, "/c5"}, S_WB_ALU, CW_WB_ALU);
    tick(); expect_st({tag, "/next"}, S_FETCH, CW_FETCH);
  endtask

  task automatic run_mem(input string tag, input logic is_load, input int delay);
    set_instr(is_load ? 7'b0000011 : 7'b0100011, 3'b010, 1'b0);
    bus.ImemReady = 1'b1;
    bus.DmemReady = 1'b0;
    tick(); expect_st({tag, "/upd"}, S_UPDATE, CW_UPDATE);
    tick(); expect_st({tag, "/dec"}, S_DECODE, CW_DECODE);
    tick(); expect_st({tag, "/addr"}, S_ADDR, CW_ADDR);
    tick();
    for (int i = 0; i <= delay; i++) begin
      if (is_load) expect_st($sformatf("%s/rd%0d", tag, i), S_MEM_RD, CW_MEM_RD);
      else         expect_st($sformatf("%s/wr%0d", tag, i), S_MEM_WR, CW_MEM_WR);
      bus.DmemReady = (i == delay);
      tick();
    end
    bus.DmemReady = 1'b0;
    if (is_load) begin
      expect_st({tag, "/wb"}, S_WB_MEM, CW_WB_MEM);
      tick();
    end
    expect_st({tag, "/next"}, S_FETCH, CW_FETCH);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    Reset         = 1'b0;
    bus.Opcode    = '0;
    bus.Funct3    = '0;
    bus.Funct7b5  = 1'b0;
    bus.ImemReady = 1'b0;
    bus.DmemReady = 1'b0;
    #1;
    do_reset("rst0");

    run_alu("add_r",  7'b0110011, 3'b000, 1'b0, S_EXEC_R, CW_EXR_ADD);
    run_alu("sra_r",  7'b0110011, 3'b101, 1'b1, S_EXEC_R, CW_EXR_SRA);
    run_alu("srai_i", 7'b0010011, 3'b101, 1'b1, S_EXEC_I, CW_EXI_SRA);
    run_alu("addi_i", 7'b0010011, 3'b000, 1'b1, S_EXEC_I, CW_EXI_ADD);

    run_mem("lw_late", 1'b1, 3);
    run_mem("sw_fast", 1'b0, 0);

    // Branch walks FETCH -> UPDATE -> DECODE -> BRANCH -> FETCH.
    set_instr(7'b1100011, 3'b000, 1'b0);
    tick(); expect_st("beq/upd", S_UPDATE, CW_UPDATE);
    tick(); expect_st("beq/dec", S_DECODE, CW_DECODE);
    tick(); expect_st("beq/br", S_BRANCH, CW_BRANCH);
    tick(); expect_st("beq/next", S_FETCH, CW_FETCH);

    // ImemReady on the 16th (limit) fetch cycle still wins, then an illegal opcode faults.
    set_instr(7'b1111111, 3'b000, 1'b0);
    bus.ImemReady = 1'b0;
    for (int i = 1; i < 16; i++) tick();
    expect_st("wd_edge/c16", S_FETCH, CW_FETCH);
    bus.ImemReady = 1'b1;
    tick(); expect_st("wd_edge/upd", S_UPDATE, CW_UPDATE);
    tick(); expect_st("ill/dec", S_DECODE, CW_DECODE);
    tick(); expect_st("ill/fault", S_FAULT, CW_FAULT);
    for (int i = 0; i < 3; i++) begin
      bus.ImemReady = i[0];
      bus.DmemReady = ~i[0];
      tick();
      expect_st($sformatf("ill/sticky%0d", i), S_FAULT, CW_FAULT);
    end
    bus.DmemReady = 1'b0;

    // ImemReady stuck low: 16 cycles in FETCH, then FAULT.
    bus.ImemReady = 1'b0;
    do_reset("rst1");
    for (int i = 1; i < 16; i++) tick();
    expect_st("wd_to/c16", S_FETCH, CW_FETCH);
    tick(); expect_st("wd_to/fault", S_FAULT, CW_FAULT);

    // Reset in the middle of a data read aborts the request immediately.
    do_reset("rst2");
    set_instr(7'b0000011, 3'b010, 1'b0);
    bus.ImemReady = 1'b1;
    tick(); tick(); tick(); tick();
    expect_st("rd_abort/mem", S_MEM_RD, CW_MEM_RD);
    #2;
    Reset = 1'b1;
    #1;
    expect_st("rd_abort/rst", S_INIT, CW_NONE);
    tick();
    Reset = 1'b0;
    expect_st("rd_abort/rel", S_INIT, CW_NONE);
    tick(); expect_st("rd_abort/fetch", S_FETCH, CW_FETCH);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
